tmds_decode_align: RTL and testbench

TMDS_DECODE_ALIGN -- requirements
Module: tmds_decode_align

---
 rtl/tmds_decode_align.sv | 179 +++++++++++++++++
 tb/tb_tmds_decode_align.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decode_align.sv
// TMDS symbol word aligner and 8b/10b data/control decoder with lock FSM.
// Optional lock-loss event counter enabled by defining TMDS_DECODE_LOCK_CNT_EN.
module tmds_decode_align #(
    parameter int unsigned LOCK_RUN     = 8,
    parameter int unsigned SLIP_TIMEOUT = 4096
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic [9:0]  tmds_raw,
    output logic [7:0]  data,
    output logic [1:0]  ctrl,
    output logic        de,
    output logic        locked,
    output logic [3:0]  bit_offset,
    output logic [15:0] lock_loss_cnt
);

    localparam logic [7:0]  RunMax  = 8'(LOCK_RUN);
    localparam logic [15:0] TmoLast = 16'(SLIP_TIMEOUT - 1);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e      state_q, state_d;
    logic [9:0]  raw_q;
    logic [9:0]  a_q, a_d;
    logic [3:0]  off_q, off_d;
    logic [7:0]  run_q, run_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  data_q, data_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        de_q, de_d;
    logic [19:0] win;
    logic        is_ctrl;
    logic [1:0]  tok;
    logic [7:0]  dbits;
    logic [7:0]  dec;
    logic        run_hit;
    logic        tmo_hit;
    logic [3:0]  off_next;

    // Lower half is the previously received word, so bit 0 is the earliest bit.
    assign win = {tmds_raw, raw_q};
    assign a_d = win[off_q +: 10];

    always_comb begin
        is_ctrl = 1'b1;
        tok     = 2'd0;
        case (a_q)
            10'h354: tok = 2'd0;
            10'h0AB: tok = 2'd1;
            10'h154: tok = 2'd2;
            10'h2AB: tok = 2'd3;
            default: is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        dbits  = a_q[9] ? ~a_q[7:0] : a_q[7:0];
        dec    = 8'd0;
        dec[0] = dbits[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = a_q[8] ? (dbits[i] ^ dbits[i-1]) : ~(dbits[i] ^ dbits[i-1]);
        end
    end

    assign run_hit  = is_ctrl && (run_q == RunMax - 8'd1);
    assign tmo_hit  = (tmo_q == TmoLast);
    assign off_next = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;

`ifdef TMDS_DECODE_LOCK_CNT_EN
    logic        loss_evt;
    logic [15:0] loss_q, loss_d;
`endif

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        tmo_d   = tmo_q + 16'd1;
        // Saturating run: once at RunMax it cannot re-trigger until a data word breaks it.
        if (!is_ctrl) begin
            run_d = 8'd0;
        end else if (run_q == RunMax) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 8'd1;
        end
`ifdef TMDS_DECODE_LOCK_CNT_EN
        loss_evt = 1'b0;
`endif
        case (state_q)
            StSearch: begin
                if (run_hit) begin
                    state_d = StLocked;
                    tmo_d   = 16'd0;
                end else if (tmo_hit) begin
                    off_d = off_next;
                    run_d = 8'd0;
                    tmo_d = 16'd0;
                end
            end
            StLocked: begin
                if (run_hit) begin
                    tmo_d = 16'd0;
                end else if (tmo_hit) begin
                    state_d = StSearch;
                    off_d   = off_next;
                    run_d   = 8'd0;
                    tmo_d   = 16'd0;
`ifdef TMDS_DECODE_LOCK_CNT_EN
                    loss_evt = 1'b1;
`endif
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_comb begin
        data_d = 8'd0;
        ctrl_d = 2'd0;
        de_d   = 1'b0;
        if (state_q == StLocked) begin
            if (is_ctrl) begin
                ctrl_d = tok;
            end else begin
                de_d   = 1'b1;
                data_d = dec;
                ctrl_d = ctrl_q;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state_q <= StSearch;
            raw_q   <= 10'd0;
            a_q     <= 10'd0;
            off_q   <= 4'd0;
            run_q   <= 8'd0;
            tmo_q   <= 16'd0;
            data_q  <= 8'd0;
            ctrl_q  <= 2'd0;
            de_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            raw_q   <= tmds_raw;
            a_q     <= a_d;
            off_q   <= off_d;
            run_q   <= run_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            de_q    <= de_d;
        end
    end

`ifdef TMDS_DECODE_LOCK_CNT_EN
    assign loss_d = (loss_evt && loss_q != 16'hFFFF) ? loss_q + 16'd1 : loss_q;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            loss_q <= 16'd0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign lock_loss_cnt = loss_q;
`else
    assign lock_loss_cnt = 16'd0;
`endif

    assign data       = data_q;
    assign ctrl       = ctrl_q;
    assign de         = de_q;
    assign locked     = (state_q == StLocked);
    assign bit_offset = off_q;

endmodule

// File: tb/tb_tmds_decode_align.sv
// Self-checking bench for tmds_decode_align: vector table through a scoreboard plus
// hand-written lock, slip, wrap, lock-loss and reset sequences.
module tb_tmds_decode_align;

    localparam int unsigned LockRun     = 8;
    localparam int unsigned SlipTimeout = 16;
`ifdef TMDS_DECODE_LOCK_CNT_EN
    localparam logic [15:0] ExpLoss = 16'd1;
`else
    localparam logic [15:0] ExpLoss = 16'd0;
`endif

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  tmds_raw = 10'd0;
    logic [7:0]  data;
    logic [1:0]  ctrl;
    logic        de;
    logic        locked;
    logic [3:0]  bit_offset;
    logic [15:0] lock_loss_cnt;

    always #5 clk_pix = ~clk_pix;

    tmds_decode_align #(
        .LOCK_RUN     (LockRun),
        .SLIP_TIMEOUT (SlipTimeout)
    ) dut (
        .clk_pix       (clk_pix),
        .rst           (rst),
        .tmds_raw      (tmds_raw),
        .data          (data),
        .ctrl          (ctrl),
        .de            (de),
        .locked        (locked),
        .bit_offset    (bit_offset),
        .lock_loss_cnt (lock_loss_cnt)
    );

    typedef struct {
        logic [9:0] word;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } vec_t;

    typedef struct {
        int         due;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one word, advance one edge, then retire any scoreboard entries now due.
    task automatic step(input logic [9:0] w);
        exp_t e;
        tmds_raw = w;
        @(posedge clk_pix);
        #1;
        cyc++;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check("sb_de", 32'(de), 32'(e.de));
            check("sb_data", 32'(data), 32'(e.data));
            check("sb_ctrl", 32'(ctrl), 32'(e.ctrl));
        end
    endtask

    task automatic send(input logic [9:0] w, input logic e_de, input logic [7:0] e_data,
                        input logic [1:0] e_ctrl);
        sbq.push_back('{due: cyc + 3, de: e_de, data: e_data, ctrl: e_ctrl});
        step(w);
    endtask

    initial begin
        vecs[0]  = '{word: 10'h100, de: 1'b1, data: 8'h00, ctrl: 2'd0};
        vecs[1]  = '{word: 10'h0AB, de: 1'b0, data: 8'h00, ctrl: 2'd1};
        vecs[2]  = '{word: 10'h2FF, de: 1'b1, data: 8'hFE, ctrl: 2'd1};
        vecs[3]  = '{word: 10'h0FF, de: 1'b1, data: 8'hFF, ctrl: 2'd1};
        vecs[4]  = '{word: 10'h155, de: 1'b1, data: 8'hFF, ctrl: 2'd0};
        vecs[5]  = '{word: 10'h154, de: 1'b0, data: 8'h00, ctrl: 2'd2};
        vecs[6]  = '{word: 10'h000, de: 1'b1, data: 8'hFE, ctrl: 2'd2};
        vecs[7]  = '{word: 10'h2AB, de: 1'b0, data: 8'h00, ctrl: 2'd3};
        vecs[8]  = '{word: 10'h10F, de: 1'b1, data: 8'h11, ctrl: 2'd0};
        vecs[9]  = '{word: 10'h20F, de: 1'b1, data: 8'hEE, ctrl: 2'd0};
        vecs[10] = '{word: 10'h2AB, de: 1'b0, data: 8'h00, ctrl: 2'd3};
        vecs[11] = '{word: 10'h1A5, de: 1'b1, data: 8'hEF, ctrl: 2'd3};

        // Reset state
        rst = 1'b1;
        step(10'h354);
        step(10'h354);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_offset", 32'(bit_offset), 32'd0);
        check("rst_loss", 32'(lock_loss_cnt), 32'd0);

        // Lock on aligned 0x354 stream: run reaches 8 at edge 10
        rst = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step(10'h354);
            if (i == 9) check("lock_early", 32'(locked), 32'd0);
            if (i == 10) begin
                check("lock_set", 32'(locked), 32'd1);
                check("lock_offset", 32'(bit_offset), 32'd0);
            end
            if (i == 11) begin
                check("lock_ctrl", 32'(ctrl), 32'd0);
                check("lock_de", 32'(de), 32'd0);
            end
        end

        // Vector table, each block of 4 followed by 8 tokens to re-arm the timeout
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 4; k++) begin
                send(vecs[4*b+k].word, vecs[4*b+k].de, vecs[4*b+k].data, vecs[4*b+k].ctrl);
            end
            for (int k = 0; k < 8; k++) send(10'h354, 1'b0, 8'h00, 2'd0);
            check("blk_locked", 32'(locked), 32'd1);
        end
        step(10'h354);
        step(10'h354);

        // Exact 3-cycle latency of a single data word
        step(10'h100);
        check("lat_c1_de", 32'(de), 32'd0);
        step(10'h354);
        check("lat_c2_de", 32'(de), 32'd0);
        step(10'h354);
        check("lat_c3_de", 32'(de), 32'd1);
        check("lat_c3_data", 32'(data), 32'd0);
        for (int i = 0; i < 6; i++) step(10'h354);

        // Lock loss after SlipTimeout cycles without a fresh run
        for (int i = 0; i < 17; i++) step(10'h100);
        check("loss_hold", 32'(locked), 32'd1);
        step(10'h100);
        check("loss_locked", 32'(locked), 32'd0);
        check("loss_offset", 32'(bit_offset), 32'd1);
        check("loss_cnt", 32'(lock_loss_cnt), 32'(ExpLoss));
        t0 = cyc;
        step(10'h100);
        check("loss_de", 32'(de), 32'd0);
        check("loss_data", 32'(data), 32'd0);

        // Offset walks 1..9 and wraps to 0 while searching
        for (int j = 1; j <= 9; j++) begin
            while (cyc < t0 + 16 * j - 1) step(10'h100);
            check("slip_before", 32'(bit_offset), 32'(j));
            step(10'h100);
            check("slip_after", 32'(bit_offset), 32'((j + 1) % 10));
        end

        // Stream rotated by 3 bits: slips 0->1->2->3 then locks at offset 3
        for (int i = 1; i <= 57; i++) begin
            step(10'h2A6);
            if (i == 15) check("rot_off0", 32'(bit_offset), 32'd0);
            if (i == 16) check("rot_off1", 32'(bit_offset), 32'd1);
            if (i == 32) check("rot_off2", 32'(bit_offset), 32'd2);
            if (i == 47) check("rot_off2_hold", 32'(bit_offset), 32'd2);
            if (i == 48) check("rot_off3", 32'(bit_offset), 32'd3);
            if (i == 56) check("rot_not_locked", 32'(locked), 32'd0);
            if (i == 57) begin
                check("rot_locked", 32'(locked), 32'd1);
                check("rot_lock_off", 32'(bit_offset), 32'd3);
            end
        end

        // Reset while locked with data in flight
        step(10'h1A5);
        step(10'h1A5);
        check("pre_rst_locked", 32'(locked), 32'd1);
        check("pre_rst_offset", 32'(bit_offset), 32'd3);
        check("pre_rst_loss", 32'(lock_loss_cnt), 32'(ExpLoss));
        rst = 1'b1;
        step(10'h1A5);
        rst = 1'b0;
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_de", 32'(de), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl), 32'd0);
        check("mid_rst_offset", 32'(bit_offset), 32'd0);
        check("mid_rst_loss", 32'(lock_loss_cnt), 32'd0);

        // Run reaches LockRun on the same edge the timeout expires: lock wins
        for (int i = 1; i <= 16; i++) begin
            step((i <= 6) ? 10'h100 : 10'h354);
            if (i == 15) check("tie_pre_locked", 32'(locked), 32'd0);
            if (i == 16) begin
                check("tie_locked", 32'(locked), 32'd1);
                check("tie_offset", 32'(bit_offset), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
